// File: rtl/cordic_result_reader.sv
// cordic_result_reader: captures sign-magnitude cos/sin pairs from the CORDIC
// gain-compensation stage, converts them to two's complement and buffers them
// in a small FIFO. The host drains the pairs over a valid/ready handshake. A
// sticky overflow flag records any pair that was dropped because the FIFO was
// full.
module cordic_result_reader #(
   parameter int DATA_WIDTH = 20,
   parameter int FRAC_WIDTH = 12,
   parameter int DEPTH      = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       data_ready,
   input  logic [DATA_WIDTH-1:0]      cos_sm_in,
   input  logic [DATA_WIDTH-1:0]      sin_sm_in,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [DATA_WIDTH-1:0]      cos_out,
   output logic [DATA_WIDTH-1:0]      sin_out,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       overflow,
   input  logic                       clear_ovf
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH) + 1;

   localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [PW-1:0] PTR_ONE  = PW'(1);

   // Pointer wrap relies on natural binary overflow, so DEPTH must be a power
   // of two. FRAC_WIDTH only documents the fixed-point format, but a value
   // that leaves no integer/sign bits is certainly a configuration mistake.
   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || FRAC_WIDTH >= DATA_WIDTH) begin : g_bad_params
      $error("cordic_result_reader: bad DEPTH/FRAC_WIDTH parameters");
   end

   // Sign-magnitude to two's complement. The magnitude is zero-extended by one
   // bit before negation, so negative zero maps to 0 and the most negative
   // code can never appear.
   function automatic logic [DATA_WIDTH-1:0] sm_to_tc(input logic [DATA_WIDTH-1:0] sm);
      logic [DATA_WIDTH-1:0] mag_ext;
      mag_ext = {1'b0, sm[DATA_WIDTH-2:0]};
      return sm[DATA_WIDTH-1] ? -mag_ext : mag_ext;
   endfunction

   // Storage: no reset needed, contents are only observed through valid_q.
   logic [DATA_WIDTH-1:0] cos_mem [DEPTH];
   logic [DATA_WIDTH-1:0] sin_mem [DEPTH];

   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q,  count_d;
   logic          valid_q,  valid_d;
   logic          ovf_q,    ovf_d;

   logic [DATA_WIDTH-1:0] cos_tc;
   logic [DATA_WIDTH-1:0] sin_tc;
   logic                  full;
   logic                  pop;
   logic                  push;
   logic                  drop;
   logic                  wr_en;

   assign cos_tc = sm_to_tc(cos_sm_in);
   assign sin_tc = sm_to_tc(sin_sm_in);

   // A pop in the same cycle frees a slot, so a full FIFO still accepts a
   // strobe when the host is draining it.
   assign full  = (count_q == CNT_FULL);
   assign pop   = valid_q & out_ready;
   assign push  = data_ready & (~full | pop);
   assign drop  = data_ready & full & ~pop;
   assign wr_en = push & ~flush;

   // Next-state for pointers, occupancy, valid and the sticky overflow flag.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      ovf_d    = ovf_q;

      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
         end
         if (push && !pop) begin
            count_d = count_q + CNT_ONE;
         end else if (pop && !push) begin
            count_d = count_q - CNT_ONE;
         end
      end

      valid_d = (count_d != '0);

      // A drop in the same cycle as clear_ovf keeps the flag set; flush
      // intentionally leaves it alone.
      if (drop) begin
         ovf_d = 1'b1;
      end else if (clear_ovf) begin
         ovf_d = 1'b0;
      end
   end

   // Control state register, cleared immediately on reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         valid_q  <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         valid_q  <= valid_d;
         ovf_q    <= ovf_d;
      end
   end

   // Write the converted pair at the write pointer on an accepted strobe.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         cos_mem[wr_ptr_q] <= cos_tc;
         sin_mem[wr_ptr_q] <= sin_tc;
      end
   end

   // Head entry is a plain read mux on registered state; masking with valid_q
   // forces the outputs to zero when empty, including right after reset.
   assign cos_out   = valid_q ? cos_mem[rd_ptr_q] : '0;
   assign sin_out   = valid_q ? sin_mem[rd_ptr_q] : '0;
   assign out_valid = valid_q;
   assign count     = count_q;
   assign overflow  = ovf_q;

endmodule
